// File: rtl/vertex_ram_sched.sv
`timescale 1ns/1ps
// vertex_ram_sched: sequencer and read-port arbiter for the banked vertex store.
//
// Shared types for the vertex store (8 x 64-bit vertices per 512-bit cacheline).
package vertex_ram_pkg;
  typedef logic [63:0] vertex_t;
endpackage

// Purpose: loads cachelines from the memory read path into the vertex store,
// then shares the single store read port between two edge requesters with
// round-robin arbitration, tagging each response with the requester ID.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, num_lines       launch a load of num_lines cachelines (IDLE only)
//   finish                 level, ends the serve phase
//   cl_valid/cl_ready/cl_data   memory cacheline stream
//   ram_cl/ram_w_addr/ram_we    store write port
//   ram_r_addr/ram_vertex       store read port (RD_LAT cycles latency)
//   req{0,1}_valid/addr/ready   requester handshakes
//   resp_valid/resp_id/resp_vertex  tagged read responses
//   load_done, done, busy  phase status to the top-level controller
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | accepting cachelines, writing each one the cycle after acceptance
// FLUSH | last line write; keeps writes and reads out of the same cycle
// SERVE | round-robin arbitration of the read port
// DRAIN | no grants; wait for outstanding responses, then pulse done
module vertex_ram_sched
  import vertex_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-3:0] num_lines,
  input  logic              finish,
  input  logic              cl_valid,
  input  logic [511:0]      cl_data,
  output logic              cl_ready,
  output logic [511:0]      ram_cl,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  vertex_t           ram_vertex,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output vertex_t           resp_vertex,
  output logic              load_done,
  output logic              done,
  output logic              busy
);

  localparam int LINE_W = ADDR_W - 3;
  localparam int NUM_W  = ADDR_W - 2;
  localparam logic [NUM_W-1:0] MAX_LINES = NUM_W'(1 << LINE_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    SERVE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state;
  logic [LINE_W-1:0]   line_cnt;
  logic [NUM_W-1:0]    lines_left;
  logic                rr_ptr;
  logic [RD_LAT-1:0]   vld_pipe;
  logic [RD_LAT-1:0]   id_pipe;
  logic [ADDR_W-1:0]   r_addr_q;
  logic                accept;
  logic                serve_open;
  logic                grant0;
  logic                grant1;
  logic                grant;

  assign accept     = (state == LOAD) && cl_ready && cl_valid;
  assign serve_open = (state == SERVE) && !finish;

  // rr_ptr names the requester that wins when both are valid.
  assign grant0 = serve_open && req0_valid && (!req1_valid || !rr_ptr);
  assign grant1 = serve_open && req1_valid && (!req0_valid ||  rr_ptr);
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Read address follows the grant and otherwise holds its last value.
  assign ram_r_addr = grant0 ? req0_addr :
                      grant1 ? req1_addr : r_addr_q;

  assign busy        = (state != IDLE);
  assign resp_valid  = vld_pipe[RD_LAT-1];
  assign resp_id     = id_pipe[RD_LAT-1];
  assign resp_vertex = ram_vertex;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cl_ready   <= 1'b0;
      ram_we     <= 1'b0;
      ram_w_addr <= '0;
      load_done  <= 1'b0;
      done       <= 1'b0;
      line_cnt   <= '0;
      lines_left <= '0;
      rr_ptr     <= 1'b0;
      vld_pipe   <= '0;
      id_pipe    <= '0;
      r_addr_q   <= '0;
    end else begin
      load_done <= 1'b0;
      done      <= 1'b0;
      ram_we    <= 1'b0;
      vld_pipe  <= {vld_pipe[RD_LAT-2:0], grant};
      id_pipe   <= {id_pipe[RD_LAT-2:0], grant1};
      r_addr_q  <= ram_r_addr;
      if (grant) rr_ptr <= grant0;

      case (state)
        IDLE: begin
          if (start) begin
            line_cnt <= '0;
            if (num_lines == '0) begin
              state     <= SERVE;
              load_done <= 1'b1;
            end else begin
              lines_left <= (num_lines > MAX_LINES) ? MAX_LINES : num_lines;
              cl_ready   <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            ram_we     <= 1'b1;
            ram_w_addr <= {line_cnt, 3'b000};
            line_cnt   <= line_cnt + 1'b1;
            lines_left <= lines_left - 1'b1;
            if (lines_left == NUM_W'(1)) begin
              cl_ready <= 1'b0;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state     <= SERVE;
          load_done <= 1'b1;
        end
        SERVE: begin
          if (finish) state <= DRAIN;
        end
        DRAIN: begin
          if (vld_pipe == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accepted line is held for the following write cycle.
  always_ff @(posedge clk) begin
    if (accept) ram_cl <= cl_data;
  end

endmodule

// File: tb/tb_vertex_ram_sched.sv
`timescale 1ns/1ps
module tb_vertex_ram_sched;
  import vertex_ram_pkg::*;

  logic          clk;
  logic          reset;
  logic          start;
  logic [5:0]    num_lines;
  logic          finish;
  logic          cl_valid;
  logic [511:0]  cl_data;
  logic          cl_ready;
  logic [511:0]  ram_cl;
  logic [7:0]    ram_w_addr;
  logic          ram_we;
  logic [7:0]    ram_r_addr;
  vertex_t       ram_vertex;
  logic          req0_valid, req1_valid;
  logic [7:0]    req0_addr, req1_addr;
  logic          req0_ready, req1_ready;
  logic          resp_valid;
  logic          resp_id;
  vertex_t       resp_vertex;
  logic          load_done, done, busy;

  vertex_ram_sched #(.ADDR_W(8), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .finish(finish), .cl_valid(cl_valid), .cl_data(cl_data),
    .cl_ready(cl_ready), .ram_cl(ram_cl), .ram_w_addr(ram_w_addr),
    .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_vertex(ram_vertex),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_vertex(resp_vertex),
    .load_done(load_done), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [511:0] line(input int v);
    return {16{32'(v)}};
  endfunction

  function automatic vertex_t vpat(input logic [7:0] a);
    return {a, 48'h1234_5678_9ABC, a};
  endfunction

  // Store read model: data for an address appears two cycles later.
  logic [7:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p1 <= ram_r_addr;
    rd_p2 <= rd_p1;
  end
  assign ram_vertex = vpat(rd_p2);

  // Response scoreboard.
  typedef struct {
    bit      id;
    vertex_t v;
    int      cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_vertex", resp_vertex, e.v);
        chk("resp_cycle", cycle, e.cyc);
      end
    end
  end

  typedef struct {
    bit         r0v;
    logic [7:0] r0a;
    bit         r1v;
    logic [7:0] r1a;
    bit         fin;
    bit         e0;
    bit         e1;
    logic [7:0] eaddr;
  } vec_t;
  vec_t tbl[11];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n, input bit toggle, input int base);
    int n_eff, acc, wr;
    bit pend, v;
    logic [511:0] pdata;
    n_eff = (n > 32) ? 32 : n;
    acc = 0; wr = 0; pend = 0; pdata = '0;
    cyc(); start = 1'b1; num_lines = 6'(n); cl_valid = 1'b0;
    @(negedge clk); chk("start_idle_busy", busy, 0);
    for (int i = 0; i < 4 * n_eff + 4; i++) begin
      cyc(); start = 1'b0;
      v = (acc < n_eff) && (!toggle || (i % 2 == 0));
      cl_valid = v; cl_data = line(base + acc);
      @(negedge clk);
      chk("cl_ready", cl_ready, acc < n_eff);
      chk("ram_we", ram_we, pend);
      if (pend) begin
        chk("ram_w_addr", ram_w_addr, wr * 8);
        chk("ram_cl", ram_cl, pdata);
        wr++;
      end
      pend = v;
      if (v) begin
        pdata = line(base + acc);
        acc++;
      end
      if (wr == n_eff && !pend) break;
    end
    chk("lines_written", wr, n_eff);
    cyc(); cl_valid = 1'b0;
    @(negedge clk);
    chk("load_done", load_done, 1);
    chk("serve_no_we", ram_we, 0);
    chk("serve_busy", busy, 1);
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); finish = 1'b0; req0_valid = 1'b1; req0_addr = 8'h11; req1_valid = 1'b0;
      @(negedge clk);
      chk("drain_no_grant", req0_ready, 0);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", got, 1);
    chk("sb_empty_at_done", sb.size(), 0);
    cyc(); req0_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic end_serve();
    cyc(); finish = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 8'h21; req1_addr = 8'h22;
    @(negedge clk);
    chk("finish_no_grant0", req0_ready, 0);
    chk("finish_no_grant1", req1_ready, 0);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_lines = '0; finish = 1'b0;
    cl_valid = 1'b0; cl_data = '0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;

    //            r0v r0a    r1v r1a    fin e0 e1 eaddr
    tbl[0]  = '{1'b1, 8'd5, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[1]  = '{1'b1, 8'd5, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9};
    tbl[2]  = '{1'b1, 8'd5, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[3]  = '{1'b1, 8'd5, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9};
    tbl[4]  = '{1'b0, 8'd5, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9};
    tbl[5]  = '{1'b0, 8'd5, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9};
    tbl[6]  = '{1'b0, 8'd5, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9};
    tbl[7]  = '{1'b1, 8'd5, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 8'd5};
    tbl[8]  = '{1'b0, 8'h77, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[9]  = '{1'b0, 8'h44, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[10] = '{1'b1, 8'd5, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 8'd3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cl_ready", cl_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    cyc(); reset = 1'b0;

    // Load four lines back-to-back, then arbitration table.
    do_load(4, 1'b0, 'hA);
    for (int i = 0; i < 11; i++) begin
      cyc();
      req0_valid = tbl[i].r0v; req0_addr = tbl[i].r0a;
      req1_valid = tbl[i].r1v; req1_addr = tbl[i].r1a;
      finish = tbl[i].fin;
      if (tbl[i].e0) sb.push_back('{1'b0, vpat(tbl[i].r0a), cycle + 2});
      if (tbl[i].e1) sb.push_back('{1'b1, vpat(tbl[i].r1a), cycle + 2});
      @(negedge clk);
      chk($sformatf("vec%0d_req0_ready", i), req0_ready, tbl[i].e0);
      chk($sformatf("vec%0d_req1_ready", i), req1_ready, tbl[i].e1);
      chk($sformatf("vec%0d_ram_r_addr", i), ram_r_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d_ram_we", i), ram_we, 0);
    end
    wait_done();

    // num_lines = 0 goes straight to SERVE.
    cyc(); start = 1'b1; num_lines = 6'd0;
    @(negedge clk); chk("zero_pre_load_done", load_done, 0);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("zero_load_done", load_done, 1);
    chk("zero_cl_ready", cl_ready, 0);
    chk("zero_ram_we", ram_we, 0);
    cyc();
    @(negedge clk);
    chk("zero_load_done_pulse", load_done, 0);
    chk("zero_ram_we2", ram_we, 0);
    end_serve();

    // Bubbled load of three lines; start in SERVE is ignored.
    do_load(3, 1'b1, 'h20);
    cyc(); start = 1'b1; num_lines = 6'd5;
    @(negedge clk);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("ign_start_cl_ready", cl_ready, 0);
    chk("ign_start_load_done", load_done, 0);
    chk("ign_start_busy", busy, 1);
    end_serve();

    // Reset in the middle of LOAD after two lines.
    cyc(); start = 1'b1; num_lines = 6'd5; cl_valid = 1'b0;
    @(negedge clk);
    cyc(); start = 1'b0; cl_valid = 1'b1; cl_data = line(1);
    @(negedge clk); chk("mid_cl_ready", cl_ready, 1);
    cyc(); cl_data = line(2);
    @(negedge clk);
    chk("mid_we0", ram_we, 1);
    chk("mid_addr0", ram_w_addr, 0);
    cyc(); reset = 1'b1; cl_data = line(3);
    @(negedge clk);
    chk("mid_we1", ram_we, 1);
    chk("mid_addr1", ram_w_addr, 8);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_cl_ready", cl_ready, 0);
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_busy", busy, 0);
    cyc(); cl_valid = 1'b0;
    do_load(2, 1'b0, 'h40);
    end_serve();

    // Oversized request clamps to the full store.
    do_load(40, 1'b0, 'h60);
    end_serve();

    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vertex_ram_sched.md
Name: vertex_ram_sched

Overview:
- Sequencer and read-port arbiter for the banked vertex store (8 vertices per 512-bit cacheline, 2-cycle read latency).
- LOAD phase: streams cachelines from the memory read path into the store at consecutive cacheline addresses.
- SERVE phase: shares the single vertex read port between two edge-processing requesters with round-robin arbitration.
- Tags each response with the requester ID and flags phase completion to the top-level phase controller.

Parameters:
- ADDR_W, 8, vertex address width; store holds 2^ADDR_W vertices, i.e. 2^(ADDR_W-3) cachelines.
- RD_LAT, 2, read latency of the vertex store in cycles (bank register plus output mux register); fixed at 2 for this revision.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- num_lines  in  ADDR_W-2  cachelines to load; latched on start.
- finish  in  1  level; ends SERVE.
- cl_valid  in  1  memory cacheline valid.
- cl_data  in  512  memory cacheline.
- cl_ready  out  1  cacheline accepted when cl_valid&&cl_ready.
- ram_cl  out  512  write data to the store.
- ram_w_addr  out  ADDR_W  address of the first vertex in the line; low 3 bits always 0.
- ram_we  out  1  store write enable.
- ram_r_addr  out  ADDR_W  store read address.
- ram_vertex  in  vertex_t  store read data, valid RD_LAT cycles after ram_r_addr.
- req0_valid / req1_valid  in  1  read request.
- req0_addr / req1_addr  in  ADDR_W  vertex address.
- req0_ready / req1_ready  out  1  grant; handshake completes when valid&&ready.
- resp_valid  out  1  response valid.
- resp_id  out  1  requester ID (0 or 1).
- resp_vertex  out  vertex_t  read data.
- load_done  out  1  one-cycle pulse on entering SERVE.
- done  out  1  one-cycle pulse on return to IDLE.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, LOAD, FLUSH, SERVE, DRAIN.
- Reset values: state=IDLE. cl_ready, ram_we, req*_ready, resp_valid, load_done, done, busy all 0. Line counter 0, RR pointer 0, response pipeline valids cleared.
- Reset mid-operation: abandons everything, so no ram_we and no resp_valid in the following cycle.
- IDLE:
  - On start, latch num_lines, clamped to 2^(ADDR_W-3).
  - num_lines=0: go directly to SERVE.
  - Otherwise go to LOAD.
  - start outside IDLE is ignored.
- LOAD:
  - cl_ready=1.
  - Each accepted line is registered; on the next cycle ram_we=1, ram_cl=line, ram_w_addr={line_cnt,3'b000}, then line_cnt++.
  - Lines are written in acceptance order with no gaps in addressing, regardless of cl_valid bubbles.
  - The cycle the last line is accepted, cl_ready drops on the following cycle and the state goes to FLUSH.
- FLUSH:
  - Single cycle; the last write (ram_we=1) occurs here.
  - Guarantees no read is issued in the same cycle as a write (the store has no read/write collision check).
  - Next state SERVE.
- SERVE entry: load_done=1 for exactly the first cycle.
- SERVE arbitration:
  - At most one grant per cycle; req*_ready is combinational from valid and the RR pointer.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester the pointer points to. After each grant, the pointer moves to the other requester.
  - ram_r_addr = granted address. When there is no grant, it holds its last value.
  - ram_we=0 throughout SERVE.
- Response pipeline:
  - Valid/ID shift register of depth RD_LAT.
  - resp_valid asserts exactly 2 cycles after the grant cycle, with resp_id = granted ID and resp_vertex = ram_vertex that cycle.
  - Back-to-back grants produce back-to-back responses.
  - No backpressure on responses; requesters must always accept them.
- finish:
  - While in SERVE, finish=1 means no grant in that cycle and the state goes to DRAIN.
  - finish outside SERVE is ignored.
- DRAIN:
  - No grants.
  - Wait until the response pipeline is empty (up to 2 cycles), then pulse done and go to IDLE.
  - A grant made in the cycle before finish still returns its response.
- Address arithmetic:
  - line_cnt is ADDR_W-3 bits and never wraps, thanks to the clamp.
  - Request addresses are used unmodified.

Test Plan:
- Reset, start with num_lines=4, cl_valid held high, lines 0xA..0xD -> ram_we on 4 consecutive cycles at ram_w_addr 0,8,16,24 with matching data; FLUSH cycle carries the addr=24 write; load_done 1 cycle later; no ram_we afterwards.
- LOAD with cl_valid toggling 1,0,1,0 for 3 lines -> 3 writes at 0,8,16; no extra writes during bubbles.
- SERVE with both requesters valid for 4 cycles, addrs 5 and 9 -> grants 0,1,0,1; resp_valid with resp_id 0,1,0,1 starting 2 cycles after the first grant; ram_r_addr 5,9,5,9.
- Only req1 valid for 3 cycles, then both valid -> req1 granted 3 times; on the first cycle both are valid, req0 wins.
- Grant on cycle t, finish at t+1 -> no grant at t+1; response at t+2; done pulse after the pipeline empties; busy=0 the cycle after.
- start with num_lines=0 -> load_done the cycle after start with no ram_we; reset asserted mid-LOAD after 2 lines -> next cycle state IDLE, cl_ready=0, ram_we=0; a fresh start reloads from address 0.
